csa_carry_resolve: RTL
======================

Name: csa_carry_resolve

Overview:
- Carry-propagate stage placed directly downstream of the 64-bit carry-save (3:2) bit-addition layer in the MDCLCG datapath.
- Takes that layer's per-bit sum vector and per-bit carry vector and resolves them into a binary result: result = sum + (carry << 1) mod 2^WIDTH.
- The adder is pipelined in SEG_W-bit segments, with one registered inter-segment carry per stage, so it meets timing at the LCG clock.
- A valid/ready handshake gives backpressure toward the generator state register.

Parameters:
- WIDTH, 64, operand and result width; must be an exact multiple of SEG_W.
- SEG_W, 16, segment width per pipeline stage; derived NSEG = WIDTH/SEG_W (4 at defaults).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sum_in/carry_in are valid this cycle.
- in_ready  out  1  stage can accept a beat this cycle.
- sum_in  in  WIDTH  per-bit sum vector from the CSA layer.
- carry_in  in  WIDTH  per-bit carry vector from the CSA layer; bit i has weight 2^(i+1).
- out_valid  out  1  result/ovf are valid.
- out_ready  in  1  consumer accepts the current output beat.
- result  out  WIDTH  (sum_in + (carry_in << 1)) mod 2^WIDTH.
- ovf  out  1  true arithmetic sum is >= 2^WIDTH.

Behaviour:
- Reset (async assert, synchronous-to-clk deassert expected):
  - All stage valid bits, inter-segment carries, result and ovf are cleared to 0.
  - out_valid = 0 during and after reset.
  - in_ready = 1 while rst_n is high and the pipe is empty.
- Pipeline advance:
  - en = !out_valid || out_ready. The whole pipe advances only when en = 1; otherwise every stage register holds its value.
  - in_ready = en (combinational from out_ready and out_valid; no combinational path from in_valid).
  - A beat is accepted iff in_valid && in_ready.
  - Bubbles are not collapsed while stalled.
- Operand formation at stage 0: B = {carry_in[WIDTH-2:0], 1'b0}; the dropped bit is carry_in[WIDTH-1].
- Stage k (k = 0..NSEG-1):
  - Adds segment k of sum and B, plus the registered carry from stage k-1 (0 for k = 0).
  - Registers the SEG_W-bit segment result and the carry-out.
  - Upper, not-yet-consumed operand segments travel in delay registers alongside the beat.
  - Completed lower result segments also travel in delay registers, so the segments of one beat stay aligned.
- Latency: exactly NSEG cycles from the accepting edge to out_valid = 1 with no stalls (4 at defaults).
- Throughput: one beat per cycle when out_ready is held at 1.
- ovf = final-stage carry-out OR carry_in[WIDTH-1]. carry_in[WIDTH-1] is delayed with the beat.
- Output hold: while out_valid && !out_ready, result and ovf are stable, and no beat is dropped or duplicated.
- Ordering: strict FIFO order; no reordering.
- Simultaneous accept and output: when out_ready = 1 and out_valid = 1, a new beat may enter in the same cycle the head beat leaves.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted afterwards.
- Unknown or X inputs while in_valid = 0 must not propagate into out_valid.

Test Plan:
- Basic add: sum_in = 0x1, carry_in = 0x1, out_ready = 1 -> exactly 4 cycles later out_valid = 1, result = 0x3, ovf = 0.
- Intra-segment carry: sum_in = 0xFFFF, carry_in = 0x8000 -> result = 0x1FFFF, ovf = 0.
- Full cross-segment ripple: sum_in = 0x0000_FFFF_FFFF_FFFF, carry_in = 0x1 -> result = 0x0001_0000_0000_0001, ovf = 0.
- Overflow cases:
  - sum_in = 0xFFFF_FFFF_FFFF_FFFF, carry_in = 0x1 -> result = 0x1, ovf = 1.
  - sum_in = 0, carry_in = 0x8000_0000_0000_0000 -> result = 0x0, ovf = 1.
- Backpressure: stream 6 beats (sum_in = n, carry_in = 0 for n = 1..6) with out_ready low for 3 cycles after the first output -> outputs 1..6 in order, none lost or repeated, result held stable during the stall, in_ready = 0 during the stall.
- Reset mid-flight: accept 3 beats, assert rst_n = 0 for 1 cycle -> out_valid = 0 immediately, and no stale results appear after release. Random back-to-back compare against a reference model for 10k beats then shows zero mismatches.

Source files
------------

// File: rtl/csa_carry_resolve.sv
// Carry-propagate stage after the 64-bit CSA layer: resolves sum + (carry << 1)
// in a pipeline of SEG_W-bit segments with a valid/ready handshake.
module csa_carry_resolve #(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_W;

    logic en;

    // Operand register: forms B = carry << 1 and keeps the dropped carry bit.
    logic             inp_v;
    logic             inp_msb;
    logic [WIDTH-1:0] inp_a;
    logic [WIDTH-1:0] inp_b;

    // NOTE: every register clears on reset, datapath included, so result and
    // ovf read as 0 from reset onward; non-blocking updates keep stages in lockstep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inp_v   <= 1'b0;
            inp_msb <= 1'b0;
            inp_a   <= '0;
            inp_b   <= '0;
        end else if (en) begin
            inp_v   <= in_valid;
            inp_msb <= carry_in[WIDTH-1];
            inp_a   <= sum_in;
            inp_b   <= {carry_in[WIDTH-2:0], 1'b0};
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int BIN_W = WIDTH - k * SEG_W;

        logic             v_in;
        logic             cy_in;
        logic             msb_in;
        logic [WIDTH-1:0] a_in;
        logic [BIN_W-1:0] b_in;
        logic [WIDTH-1:0] a_nxt;
        logic [SEG_W:0]   seg_sum;

        logic             v_r;
        logic             cy_r;
        logic             msb_r;
        logic [WIDTH-1:0] a_r;

        if (k == 0) begin : g_head
            assign v_in   = inp_v;
            assign cy_in  = 1'b0;
            assign msb_in = inp_msb;
            assign a_in   = inp_a;
            assign b_in   = inp_b;
        end else begin : g_body
            assign v_in   = g_stage[k-1].v_r;
            assign cy_in  = g_stage[k-1].cy_r;
            assign msb_in = g_stage[k-1].msb_r;
            assign a_in   = g_stage[k-1].a_r;
            assign b_in   = g_stage[k-1].g_fwd.b_r;
        end

        assign seg_sum = {1'b0, a_in[SEG_W-1:0]} + {1'b0, b_in[SEG_W-1:0]}
                       + {{SEG_W{1'b0}}, cy_in};

        // The accumulator rotates right one segment per stage: the finished
        // segment enters at the top, so after NSEG stages it is in place.
        always_comb begin
            a_nxt = a_in >> SEG_W;
            a_nxt[WIDTH-SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                cy_r  <= 1'b0;
                msb_r <= 1'b0;
                a_r   <= '0;
            end else if (en) begin
                v_r   <= v_in;
                cy_r  <= seg_sum[SEG_W];
                msb_r <= msb_in;
                a_r   <= a_nxt;
            end
        end

        // Only the not-yet-consumed upper part of B travels on.
        if (k < NSEG - 1) begin : g_fwd
            logic [BIN_W-SEG_W-1:0] b_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_r <= '0;
                end else if (en) begin
                    b_r <= b_in[BIN_W-1:SEG_W];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].v_r;
    assign result    = g_stage[NSEG-1].a_r;
    assign ovf       = g_stage[NSEG-1].cy_r | g_stage[NSEG-1].msb_r;
    assign en        = !out_valid || out_ready;
    assign in_ready  = en;

endmodule
